// File: rtl/axi_param_ctrl_mc.sv
// Multi-channel AXI-lite parameter controller: one global page (soft reset, ID, sync)
// plus NUM_CH channel pages (GPIO enable, DMA length, arm/done handshake, tlast counter).
module axi_param_ctrl_mc #(
  parameter int          NUM_CH          = 4,
  parameter logic [31:0] C_AXI_ADDR_BASE = 32'h4000_F000,
  parameter logic [31:0] CH_STRIDE       = 32'h100,
  parameter int          RST_PULSE_CYC   = 16,
  parameter int          SYNC_PULSE_CYC  = 4,
  parameter logic [31:0] ID_VALUE        = 32'h646d_6e00
) (
  input  logic                  axiclk,
  input  logic                  rst,
  input  logic [31:0]           S_AXI_WDATA_ext,
  input  logic [31:0]           axi_awaddr,
  input  logic [31:0]           axi_araddr,
  input  logic                  slv_reg_wren,
  input  logic                  slv_reg_rden,
  output logic [31:0]           S_AXI_RDATA_ext,
  output logic                  o_hp_sw_rst_n,
  output logic [NUM_CH-1:0]     o_sync_pulse,
  output logic [32*NUM_CH-1:0]  o_gpio_en,
  output logic [32*NUM_CH-1:0]  o_dma_len,
  output logic [NUM_CH-1:0]     o_dma_arm,
  input  logic [NUM_CH-1:0]     i_tlast_evt
);

  localparam int RW = $clog2(RST_PULSE_CYC + 1);
  localparam int SW = $clog2(SYNC_PULSE_CYC + 1);

  function automatic logic [31:0] ch_base(input int ch);
    return C_AXI_ADDR_BASE + CH_STRIDE * 32'(ch + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic                rstn_q;
  logic [SW-1:0]       scnt_q [NUM_CH];
  logic [SW-1:0]       scnt_d [NUM_CH];
  logic [NUM_CH-1:0]   sync_q;
  logic [31:0]         gpio_q [NUM_CH];
  logic [31:0]         gpio_d [NUM_CH];
  logic [31:0]         len_q  [NUM_CH];
  logic [31:0]         len_d  [NUM_CH];
  logic [31:0]         tcnt_q [NUM_CH];
  logic [31:0]         tcnt_d [NUM_CH];
  logic [NUM_CH-1:0]   arm_q, arm_d, done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                g_ctrl_wr, g_sync_wr;

  assign g_ctrl_wr = slv_reg_wren && (axi_awaddr == C_AXI_ADDR_BASE);
  assign g_sync_wr = slv_reg_wren && (axi_awaddr == C_AXI_ADDR_BASE + 32'h8);

  always_comb begin
    rcnt_d = rcnt_q;
    if (g_ctrl_wr && S_AXI_WDATA_ext[0]) rcnt_d = RW'(RST_PULSE_CYC);
    else if (rcnt_q != '0)               rcnt_d = rcnt_q - RW'(1);

    for (int ch = 0; ch < NUM_CH; ch++) begin
      scnt_d[ch] = scnt_q[ch];
      if (g_sync_wr && S_AXI_WDATA_ext[ch]) scnt_d[ch] = SW'(SYNC_PULSE_CYC);
      else if (scnt_q[ch] != '0)            scnt_d[ch] = scnt_q[ch] - SW'(1);

      gpio_d[ch] = gpio_q[ch];
      len_d[ch]  = len_q[ch];
      if (slv_reg_wren && axi_awaddr == ch_base(ch))         gpio_d[ch] = S_AXI_WDATA_ext;
      if (slv_reg_wren && axi_awaddr == ch_base(ch) + 32'h4) len_d[ch]  = S_AXI_WDATA_ext;

      // Arm write beats the event's clear; the event's done-set beats W1C.
      arm_d[ch]  = arm_q[ch];
      done_d[ch] = done_q[ch];
      if (slv_reg_wren && axi_awaddr == ch_base(ch) + 32'hC && S_AXI_WDATA_ext[1])
        done_d[ch] = 1'b0;
      if (arm_q[ch] && i_tlast_evt[ch]) begin
        arm_d[ch]  = 1'b0;
        done_d[ch] = 1'b1;
      end
      if (slv_reg_wren && axi_awaddr == ch_base(ch) + 32'h8 && S_AXI_WDATA_ext[0])
        arm_d[ch] = 1'b1;

      if (slv_reg_rden && axi_araddr == ch_base(ch) + 32'h10)
        tcnt_d[ch] = i_tlast_evt[ch] ? 32'd1 : 32'd0;
      else if (i_tlast_evt[ch])
        tcnt_d[ch] = sat_inc(tcnt_q[ch]);
      else
        tcnt_d[ch] = tcnt_q[ch];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (axi_araddr == C_AXI_ADDR_BASE)              rdata_d = {31'b0, ~rstn_q};
    else if (axi_araddr == C_AXI_ADDR_BASE + 32'h4) rdata_d = {ID_VALUE[31:8], 8'(NUM_CH)};
    else if (axi_araddr == C_AXI_ADDR_BASE + 32'h8) rdata_d = 32'(sync_q);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (axi_araddr == ch_base(ch))                rdata_d = gpio_q[ch];
      else if (axi_araddr == ch_base(ch) + 32'h4)   rdata_d = len_q[ch];
      else if (axi_araddr == ch_base(ch) + 32'hC)   rdata_d = {30'b0, done_q[ch], arm_q[ch]};
      else if (axi_araddr == ch_base(ch) + 32'h10)  rdata_d = tcnt_q[ch];
    end
  end

  always_ff @(posedge axiclk or posedge rst) begin
    if (rst) begin
      rcnt_q  <= '0;
      rstn_q  <= 1'b1;
      sync_q  <= '0;
      arm_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        scnt_q[ch] <= '0;
        gpio_q[ch] <= '0;
        len_q[ch]  <= 32'h0000_1000;
        tcnt_q[ch] <= '0;
      end
    end else begin
      rcnt_q <= rcnt_d;
      rstn_q <= (rcnt_d == '0);
      arm_q  <= arm_d;
      done_q <= done_d;
      if (slv_reg_rden) rdata_q <= rdata_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        scnt_q[ch] <= scnt_d[ch];
        sync_q[ch] <= (scnt_d[ch] != '0);
        gpio_q[ch] <= gpio_d[ch];
        len_q[ch]  <= len_d[ch];
        tcnt_q[ch] <= tcnt_d[ch];
      end
    end
  end

  always_comb begin
    o_gpio_en = '0;
    o_dma_len = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      o_gpio_en[32*ch +: 32] = gpio_q[ch];
      o_dma_len[32*ch +: 32] = len_q[ch];
    end
  end

  assign S_AXI_RDATA_ext = rdata_q;
  assign o_hp_sw_rst_n   = rstn_q;
  assign o_sync_pulse    = sync_q;
  assign o_dma_arm       = arm_q;

endmodule

// File: tb/tb_axi_param_ctrl_mc.sv
// Directed bench for axi_param_ctrl_mc; read expectations flow through a scoreboard queue.
module tb_axi_param_ctrl_mc;
  localparam int NUM_CH = 4;

  logic                 axiclk;
  logic                 rst;
  logic [31:0]          S_AXI_WDATA_ext;
  logic [31:0]          axi_awaddr;
  logic [31:0]          axi_araddr;
  logic                 slv_reg_wren;
  logic                 slv_reg_rden;
  logic [31:0]          S_AXI_RDATA_ext;
  logic                 o_hp_sw_rst_n;
  logic [NUM_CH-1:0]    o_sync_pulse;
  logic [32*NUM_CH-1:0] o_gpio_en;
  logic [32*NUM_CH-1:0] o_dma_len;
  logic [NUM_CH-1:0]    o_dma_arm;
  logic [NUM_CH-1:0]    i_tlast_evt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  axi_param_ctrl_mc #(.NUM_CH(NUM_CH)) dut (
    .axiclk(axiclk), .rst(rst),
    .S_AXI_WDATA_ext(S_AXI_WDATA_ext), .axi_awaddr(axi_awaddr), .axi_araddr(axi_araddr),
    .slv_reg_wren(slv_reg_wren), .slv_reg_rden(slv_reg_rden),
    .S_AXI_RDATA_ext(S_AXI_RDATA_ext), .o_hp_sw_rst_n(o_hp_sw_rst_n),
    .o_sync_pulse(o_sync_pulse), .o_gpio_en(o_gpio_en), .o_dma_len(o_dma_len),
    .o_dma_arm(o_dma_arm), .i_tlast_evt(i_tlast_evt)
  );

  initial axiclk = 1'b0;
  always #5 axiclk = ~axiclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge after the sampling edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [NUM_CH-1:0] evt);
    axi_awaddr = addr; S_AXI_WDATA_ext = data; slv_reg_wren = 1'b1; i_tlast_evt = evt;
    @(negedge axiclk);
    slv_reg_wren = 1'b0; i_tlast_evt = '0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                    input logic [NUM_CH-1:0] evt);
    axi_araddr = addr; slv_reg_rden = 1'b1; i_tlast_evt = evt;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(negedge axiclk);
    slv_reg_rden = 1'b0; i_tlast_evt = '0;
    if (exp_q.size() == 0) chk("sb_empty", 128'(1), 128'(0));
    else chk(tag_q.pop_front(), 128'(S_AXI_RDATA_ext), 128'(exp_q.pop_front()));
  endtask

  task automatic evt_pulses(input int n, input logic [NUM_CH-1:0] evt);
    for (int i = 0; i < n; i++) begin
      i_tlast_evt = evt;
      @(negedge axiclk);
    end
    i_tlast_evt = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1; S_AXI_WDATA_ext = '0; axi_awaddr = '0; axi_araddr = '0;
    slv_reg_wren = 1'b0; slv_reg_rden = 1'b0; i_tlast_evt = '0;
    repeat (3) @(negedge axiclk);
    chk("rst_rdata", 128'(S_AXI_RDATA_ext), 128'(0));
    chk("rst_rstn",  128'(o_hp_sw_rst_n), 128'(1));
    chk("rst_sync",  128'(o_sync_pulse), 128'(0));
    chk("rst_gpio",  o_gpio_en, 128'(0));
    chk("rst_len",   o_dma_len, {4{32'h0000_1000}});
    chk("rst_arm",   128'(o_dma_arm), 128'(0));
    rst = 1'b0;
    @(negedge axiclk);

    rd(32'h4000_F004, 32'h646d_6e04, "id", '0);
    @(negedge axiclk);
    chk("rdata_hold", 128'(S_AXI_RDATA_ext), 128'(32'h646d_6e04));
    rd(32'h4000_F104, 32'h0000_1000, "len0_rst", '0);
    rd(32'h4000_F500, 32'h0, "unmapped_page", '0);

    // Soft-reset pulse width
    wr(32'h4000_F000, 32'h1, '0);
    n = 0;
    while (!o_hp_sw_rst_n && n < 100) begin n++; @(negedge axiclk); end
    chk("rst_pulse16", 128'(n), 128'(16));

    // Retrigger on the tenth low cycle
    wr(32'h4000_F000, 32'h1, '0);
    n = 0;
    while (!o_hp_sw_rst_n && n < 100) begin
      n++;
      slv_reg_wren = (n == 10);
      @(negedge axiclk);
    end
    slv_reg_wren = 1'b0;
    chk("rst_pulse26", 128'(n), 128'(26));

    wr(32'h4000_F008, 32'hA, '0);
    for (int i = 0; i < 4; i++) begin
      chk("sync_high", 128'(o_sync_pulse), 128'(4'b1010));
      @(negedge axiclk);
    end
    chk("sync_low", 128'(o_sync_pulse), 128'(0));

    wr(32'h4000_F308, 32'h1, '0);
    chk("arm2_set", 128'(o_dma_arm), 128'(4'b0100));
    evt_pulses(1, 4'b0100);
    chk("arm2_clr", 128'(o_dma_arm), 128'(0));
    rd(32'h4000_F30C, 32'h2, "status2_done", '0);
    wr(32'h4000_F30C, 32'h2, '0);
    rd(32'h4000_F30C, 32'h0, "status2_w1c", '0);

    // Arm write and done-setting event in the same cycle
    wr(32'h4000_F208, 32'h1, '0);
    wr(32'h4000_F208, 32'h1, 4'b0010);
    rd(32'h4000_F20C, 32'h3, "arm_wins", '0);
    wr(32'h4000_F20C, 32'h2, 4'b0010);
    rd(32'h4000_F20C, 32'h2, "set_wins", '0);
    wr(32'h4000_F20C, 32'h2, '0);
    rd(32'h4000_F20C, 32'h0, "status1_clr", '0);

    evt_pulses(5, 4'b0001);
    rd(32'h4000_F110, 32'd5, "tcnt5", '0);
    rd(32'h4000_F110, 32'd0, "tcnt_cor", '0);
    evt_pulses(3, 4'b0001);
    rd(32'h4000_F110, 32'd3, "tcnt_rd_evt", 4'b0001);
    rd(32'h4000_F110, 32'd1, "tcnt_after", '0);

    wr(32'h4000_F200, 32'hDEAD_BEEF, '0);
    chk("gpio1", 128'(o_gpio_en[63:32]), 128'(32'hDEAD_BEEF));
    rd(32'h4000_F200, 32'hDEAD_BEEF, "gpio1_rd", '0);
    wr(32'h4000_F404, 32'h0000_0040, '0);
    chk("len3", 128'(o_dma_len[127:96]), 128'(32'h0000_0040));
    wr(32'h4000_F408, 32'h1, '0);
    wr(32'h4000_F000, 32'h1, '0);
    wr(32'h4000_F008, 32'hF, '0);
    chk("sync_all", 128'(o_sync_pulse), 128'(4'hF));

    // Asynchronous reset mid-pulse
    #2 rst = 1'b1;
    #1;
    chk("arst_rdata", 128'(S_AXI_RDATA_ext), 128'(0));
    chk("arst_rstn",  128'(o_hp_sw_rst_n), 128'(1));
    chk("arst_sync",  128'(o_sync_pulse), 128'(0));
    chk("arst_gpio",  o_gpio_en, 128'(0));
    chk("arst_len",   o_dma_len, {4{32'h0000_1000}});
    chk("arst_arm",   128'(o_dma_arm), 128'(0));
    @(negedge axiclk);
    rst = 1'b0;
    @(negedge axiclk);
    rd(32'h4000_F110, 32'd0, "arst_tcnt", '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
